// File: rtl/bomb_countdown_timer.sv
// bomb_countdown_timer
// Millisecond countdown for the six-digit display stage. Holds a linear
// 24-bit count, decrements it once per prescaled tick, subtracts a penalty
// on wrong-answer strikes and flags expiry (the bomb "explode" condition).
// Optional feature macro: BOMB_TIMER_WARN_BLINK_EN blinks the display
// enable while running below WARN_THRESH and while expired; without it
// disp_on is tied high.

module bomb_countdown_timer #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned START_VALUE = 300000,
  parameter int unsigned PENALTY     = 10000,
  parameter int unsigned WARN_THRESH = 30000,
  parameter int unsigned BLINK_DIV   = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] load_value,
  input  logic        start,
  input  logic        pause,
  input  logic        strike,
  output logic [23:0] count,
  output logic        running,
  output logic        expired,
  output logic        tick,
  output logic        disp_on
);

  // Largest displayable value, 59:59.999.
  localparam logic [23:0] MAX_COUNT  = 24'd3599999;
  localparam logic [23:0] PENALTY_24 = 24'(PENALTY);
  localparam int          PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_t;

  // Reject configurations the arithmetic below does not cover.
  if (TICK_DIV < 2 || BLINK_DIV < 1 || WARN_THRESH > 3599999 ||
      START_VALUE > 3599999 || PENALTY >= 16777215) begin : g_bad_params
    $error("bomb_countdown_timer: parameter out of range");
  end

  state_t          state_q;
  state_t          state_n;
  logic [PW-1:0]   presc_q;
  logic [PW-1:0]   presc_n;
  logic [23:0]     count_n;
  logic [23:0]     sub;
  logic [23:0]     load_clamped;
  logic            tick_n;
  logic            wrap;
`ifdef BOMB_TIMER_WARN_BLINK_EN
  logic            blink_step_n;
`endif

  assign wrap         = (presc_q == PRESC_LAST);
  assign load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

  // Next-state, next-count and prescaler decisions in priority order:
  // load > strike > pause > start > tick decrement.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n = state_q;
    count_n = count;
    presc_n = presc_q;
    tick_n  = 1'b0;
    sub     = '0;
`ifdef BOMB_TIMER_WARN_BLINK_EN
    blink_step_n = 1'b0;
`endif
    if (load) begin
      count_n = load_clamped;
      presc_n = '0;
      state_n = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !pause) begin
            state_n = (count == '0) ? EXPIRED : RUN;
          end
        end
        RUN: begin
          if (!pause) begin
            if (wrap) begin
              presc_n = '0;
              tick_n  = 1'b1;
              sub     = 24'd1;
            end else begin
              presc_n = presc_q + PRESC_ONE;
            end
          end
          if (strike) begin
            sub = sub + PENALTY_24;
          end
          // Guard compared before subtracting so the count never wraps.
          count_n = (count > sub) ? (count - sub) : '0;
          if (count_n == '0) begin
            state_n = EXPIRED;
          end else if (pause) begin
            state_n = PAUSED;
          end
`ifdef BOMB_TIMER_WARN_BLINK_EN
          blink_step_n = tick_n;
`endif
        end
        PAUSED: begin
          if (strike) begin
            count_n = (count > PENALTY_24) ? (count - PENALTY_24) : '0;
          end
          if (count_n == '0) begin
            state_n = EXPIRED;
          end else if (start && !pause) begin
            // Prescaler is left untouched so the resumed tick keeps its phase.
            state_n = RUN;
          end
        end
        EXPIRED: begin
          count_n = '0;
          // Prescaler free-runs here only to pace the expired blink.
          presc_n = wrap ? '0 : (presc_q + PRESC_ONE);
`ifdef BOMB_TIMER_WARN_BLINK_EN
          blink_step_n = wrap;
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, count, prescaler and status flags, all registered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      count   <= 24'(START_VALUE);
      presc_q <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state_q <= state_n;
      count   <= count_n;
      presc_q <= presc_n;
      running <= (state_n == RUN);
      // Rises the cycle after EXPIRED is entered; only load clears it.
      expired <= (state_q == EXPIRED) && !load;
      tick    <= tick_n;
    end
  end

`ifdef BOMB_TIMER_WARN_BLINK_EN
  localparam int            BW          = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [BW-1:0] BLINK_ONE   = BW'(1);
  localparam logic [23:0]   WARN_24     = 24'(WARN_THRESH);

  logic [BW-1:0] blink_cnt;
  logic          warn_q;
  logic          warn_n;

  assign warn_n = ((state_n == RUN) && (count_n < WARN_24)) || (state_n == EXPIRED);

  // Blink the display enable while in the warning region or expired;
  // the blink counter restarts, display on, on every entry to that region.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_on   <= 1'b1;
      blink_cnt <= '0;
      warn_q    <= 1'b0;
    end else begin
      warn_q <= warn_n;
      if (!warn_n || !warn_q) begin
        disp_on   <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_step_n) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          disp_on   <= ~disp_on;
        end else begin
          blink_cnt <= blink_cnt + BLINK_ONE;
        end
      end
    end
  end
`else
  assign disp_on = 1'b1;
`endif

endmodule

// File: tb/tb_bomb_countdown_timer.sv
// tb_bomb_countdown_timer
// Directed bench for bomb_countdown_timer with TICK_DIV=4 and BLINK_DIV=2:
// a table of single-cycle vectors followed by multi-cycle sequences.
// Honours BOMB_TIMER_WARN_BLINK_EN for the disp_on expectations.

module tb_bomb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [23:0] load_value;
  logic        start;
  logic        pause;
  logic        strike;
  logic [23:0] count;
  logic        running;
  logic        expired;
  logic        tick;
  logic        disp_on;

  int n_checks = 0;
  int n_fail   = 0;

  bomb_countdown_timer #(
    .TICK_DIV   (4),
    .START_VALUE(300000),
    .PENALTY    (10000),
    .WARN_THRESH(30000),
    .BLINK_DIV  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_value(load_value),
    .start     (start),
    .pause     (pause),
    .strike    (strike),
    .count     (count),
    .running   (running),
    .expired   (expired),
    .tick      (tick),
    .disp_on   (disp_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [23:0] lv;
    logic        st;
    logic        pa;
    logic        sk;
    logic [23:0] cnt;
    logic        run;
    logic        exp;
    logic        tk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ld, int lv, logic st, logic pa, logic sk,
                              int cnt, logic run, logic exp, logic tk);
    vec_t v;
    v.ld = ld; v.lv = 24'(lv); v.st = st; v.pa = pa; v.sk = sk;
    v.cnt = 24'(cnt); v.run = run; v.exp = exp; v.tk = tk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; load_value = '0; start = 1'b0; pause = 1'b0; strike = 1'b0;
  endtask

  // Watchdog: the bench never waits open-ended, this is a last resort.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ticks;
    logic exp_blink_lo;

`ifdef BOMB_TIMER_WARN_BLINK_EN
    exp_blink_lo = 1'b0;
`else
    exp_blink_lo = 1'b1;
`endif

    // ld lv st pa sk | cnt run exp tk
    vecs.push_back(mk(1, 100,     0, 0, 0,  100,     0, 0, 0)); // 0 load
    vecs.push_back(mk(0, 0,       1, 0, 0,  100,     1, 0, 0)); // 1 start
    vecs.push_back(mk(0, 0,       0, 0, 0,  100,     1, 0, 0)); // 2 presc 1
    vecs.push_back(mk(0, 0,       0, 0, 0,  100,     1, 0, 0)); // 3 presc 2
    vecs.push_back(mk(0, 0,       0, 0, 0,  100,     1, 0, 0)); // 4 presc 3
    vecs.push_back(mk(0, 0,       0, 0, 0,  99,      1, 0, 1)); // 5 tick
    vecs.push_back(mk(0, 0,       0, 1, 0,  99,      0, 0, 0)); // 6 pause
    vecs.push_back(mk(0, 0,       1, 1, 0,  99,      0, 0, 0)); // 7 pause wins
    vecs.push_back(mk(0, 0,       1, 0, 0,  99,      1, 0, 0)); // 8 resume
    vecs.push_back(mk(0, 0,       0, 0, 0,  99,      1, 0, 0)); // 9
    vecs.push_back(mk(0, 0,       0, 0, 0,  99,      1, 0, 0)); // 10
    vecs.push_back(mk(0, 0,       0, 0, 0,  99,      1, 0, 0)); // 11
    vecs.push_back(mk(0, 0,       0, 0, 0,  98,      1, 0, 1)); // 12 tick
    vecs.push_back(mk(0, 0,       0, 0, 1,  0,       0, 0, 0)); // 13 strike to 0
    vecs.push_back(mk(0, 0,       0, 0, 0,  0,       0, 1, 0)); // 14 expired
    vecs.push_back(mk(0, 0,       1, 0, 1,  0,       0, 1, 0)); // 15 ignored
    vecs.push_back(mk(1, 4000000, 0, 0, 0,  3599999, 0, 0, 0)); // 16 clamp
    vecs.push_back(mk(0, 0,       0, 0, 1,  3599999, 0, 0, 0)); // 17 strike idle
    vecs.push_back(mk(0, 0,       0, 1, 0,  3599999, 0, 0, 0)); // 18 pause idle
    vecs.push_back(mk(1, 10001,   0, 0, 0,  10001,   0, 0, 0)); // 19 load
    vecs.push_back(mk(0, 0,       1, 0, 0,  10001,   1, 0, 0)); // 20 start
    vecs.push_back(mk(0, 0,       0, 0, 0,  10001,   1, 0, 0)); // 21
    vecs.push_back(mk(0, 0,       0, 0, 0,  10001,   1, 0, 0)); // 22
    vecs.push_back(mk(0, 0,       0, 0, 0,  10001,   1, 0, 0)); // 23
    vecs.push_back(mk(0, 0,       0, 0, 1,  0,       0, 0, 1)); // 24 strike+tick
    vecs.push_back(mk(0, 0,       0, 0, 0,  0,       0, 1, 0)); // 25
    vecs.push_back(mk(1, 0,       0, 0, 0,  0,       0, 0, 0)); // 26 load 0
    vecs.push_back(mk(0, 0,       1, 0, 0,  0,       0, 0, 0)); // 27 straight to EXPIRED
    vecs.push_back(mk(0, 0,       0, 0, 0,  0,       0, 1, 0)); // 28

    // Reset overrides load/start asserted in the same cycle.
    idle_inputs();
    rst = 1'b1; load = 1'b1; load_value = 24'd7; start = 1'b1;
    step();
    step();
    idle_inputs();
    rst = 1'b0;
    check("rst_count",   32'(count),   32'd300000);
    check("rst_running", 32'(running), 32'd0);
    check("rst_expired", 32'(expired), 32'd0);
    check("rst_tick",    32'(tick),    32'd0);
    check("rst_disp_on", 32'(disp_on), 32'd1);

    // Table-driven single-cycle vectors.
    foreach (vecs[i]) begin
      load = vecs[i].ld; load_value = vecs[i].lv;
      start = vecs[i].st; pause = vecs[i].pa; strike = vecs[i].sk;
      step();
      check($sformatf("vec%0d_count", i),   32'(count),   32'(vecs[i].cnt));
      check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].run));
      check($sformatf("vec%0d_expired", i), 32'(expired), 32'(vecs[i].exp));
      check($sformatf("vec%0d_tick", i),    32'(tick),    32'(vecs[i].tk));
    end
    idle_inputs();

    // Reset then a single-cycle start: first decrement 4 clocks after RUN entry.
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("a_running", 32'(running), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("a_hold%0d", k), 32'(count), 32'd300000);
    end
    step();
    check("a_first_dec",  32'(count), 32'd299999);
    check("a_first_tick", 32'(tick),  32'd1);
    ticks = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (tick) ticks++;
    end
    check("a_tick_count", 32'(ticks), 32'd3);
    check("a_count_end",  32'(count), 32'd299996);

    // load 5, run to expiry, then inputs other than load are ignored.
    load = 1'b1; load_value = 24'd5;
    step();
    load = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      n = k;
      if (expired) break;
    end
    check("b_expiry_latency", 32'(n),       32'd21);
    check("b_count",          32'(count),   32'd0);
    check("b_running",        32'(running), 32'd0);
    start = 1'b1; strike = 1'b1;
    step();
    idle_inputs();
    check("b_ignored_count",   32'(count),   32'd0);
    check("b_ignored_expired", 32'(expired), 32'd1);

    // Strike penalties, saturating at 0.
    load = 1'b1; load_value = 24'd25000;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0; strike = 1'b1;
    step();
    strike = 1'b0;
    check("c_strike1", 32'(count), 32'd15000);
    load = 1'b1; load_value = 24'd8000;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0; strike = 1'b1;
    step();
    strike = 1'b0;
    check("c_strike2_sat", 32'(count),   32'd0);
    check("c_running",     32'(running), 32'd0);
    step();
    check("c_expired",     32'(expired), 32'd1);
    check("c_count_held",  32'(count),   32'd0);

    // Pause at prescaler 2, hold 10 clocks, resume: decrement 2 clocks later.
    load = 1'b1; load_value = 24'd1000;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("d_paused%0d", k), 32'(count), 32'd1000);
    end
    check("d_paused_running", 32'(running), 32'd0);
    pause = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("d_resumed", 32'(running), 32'd1);
    step();
    check("d_no_dec_yet", 32'(count), 32'd1000);
    step();
    check("d_dec",  32'(count), 32'd999);
    check("d_tick", 32'(tick),  32'd1);

    // Warning region blink (or steady enable when the feature is off).
    load = 1'b1; load_value = 24'd30005;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      step();
      check($sformatf("e_disp_pre%0d", k), 32'(disp_on), 32'd1);
      if (k == 24) check("e_count_warn", 32'(count), 32'd29999);
    end
    for (int k = 32; k <= 39; k++) begin
      step();
      check($sformatf("e_disp_lo%0d", k), 32'(disp_on), 32'(exp_blink_lo));
    end
    step();
    check("e_disp_back", 32'(disp_on), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
